// File: rtl/ram_alu_sequencer_if.sv
// Command, response and RAM_ALU port bundle for the RAM_ALU sequencer.
`timescale 1ns/1ps
interface ram_alu_sequencer_if #(
  parameter int DW = 16,
  parameter int RW = 32
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_x;
  logic [DW-1:0] cmd_y;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          alu_e;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_din;
  logic [1:0]    alu_addr;
  logic          alu_w;
  logic          alu_r;
  logic [RW-1:0] alu_dout;

  // Environment side: issues commands, consumes responses, models RAM_ALU read data
  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, rsp_ready, alu_dout,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
           alu_e, alu_op, alu_din, alu_addr, alu_w, alu_r
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, rsp_ready, alu_dout,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
           alu_e, alu_op, alu_din, alu_addr, alu_w, alu_r
  );
endinterface

// File: rtl/ram_alu_sequencer.sv
// Command-level controller for the RAM_ALU block: writes X to addr 0, Y to addr 1,
// reads the result from addr 2 and returns it on a valid/ready response channel.
// Zero-divisor commands are answered with an error without touching RAM_ALU.
`timescale 1ns/1ps
module ram_alu_sequencer #(
  parameter int DW      = 16,
  parameter int RW      = 32,
  parameter int RD_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  ram_alu_sequencer_if.slave bus
);

  localparam int            CW   = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(RD_WAIT - 1);

  typedef enum logic [2:0] {IDLE, WR_X, WR_Y, RD, RESP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_y;
  logic          r_cmd_ready;
  logic          r_rsp_valid;
  logic [RW-1:0] r_rsp_data;
  logic          r_rsp_err;
  logic          r_busy;
  logic          r_alu_e;
  logic [1:0]    r_alu_op;
  logic [DW-1:0] r_alu_din;
  logic [1:0]    r_alu_addr;
  logic          r_alu_w;
  logic          r_alu_r;

  logic [DW-1:0] w_diff;
  logic          w_err;

  // Divisor screen on the incoming command; X==Y uses the DW-bit wrap of X-Y
  always_comb begin
    w_diff = bus.cmd_x - bus.cmd_y;
    w_err  = (((bus.cmd_op == 2'd1) || (bus.cmd_op == 2'd2)) && (bus.cmd_y == '0)) ||
             ((bus.cmd_op == 2'd3) && (w_diff == '0));
  end

  // Sequencer FSM; every output is a register so the RAM_ALU strobes are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_y         <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_alu_e     <= 1'b0;
      r_alu_op    <= 2'd0;
      r_alu_din   <= '0;
      r_alu_addr  <= 2'd0;
      r_alu_w     <= 1'b0;
      r_alu_r     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_y         <= bus.cmd_y;
            if (w_err) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state    <= WR_X;
              r_alu_e    <= 1'b1;
              r_alu_op   <= bus.cmd_op;
              r_alu_addr <= 2'd0;
              r_alu_din  <= bus.cmd_x;
              r_alu_w    <= 1'b1;
              r_alu_r    <= 1'b0;
            end
          end
        end
        WR_X: begin
          r_state    <= WR_Y;
          r_alu_addr <= 2'd1;
          r_alu_din  <= r_y;
        end
        WR_Y: begin
          r_state    <= RD;
          r_alu_addr <= 2'd2;
          r_alu_din  <= '0;
          r_alu_w    <= 1'b0;
          r_alu_r    <= 1'b1;
          r_cnt      <= '0;
        end
        RD: begin
          if (r_cnt == LAST) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.alu_dout;
            r_rsp_err   <= 1'b0;
            r_alu_e     <= 1'b0;
            r_alu_op    <= 2'd0;
            r_alu_addr  <= 2'd0;
            r_alu_r     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = r_busy;
  assign bus.alu_e     = r_alu_e;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_din   = r_alu_din;
  assign bus.alu_addr  = r_alu_addr;
  assign bus.alu_w     = r_alu_w;
  assign bus.alu_r     = r_alu_r;

endmodule

// File: tb/tb_ram_alu_sequencer.sv
// Directed self-checking bench for ram_alu_sequencer with a small RAM_ALU stand-in.
`timescale 1ns/1ps
module tb_ram_alu_sequencer;

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   errorCount = 0;

  ram_alu_sequencer_if #(.DW(16), .RW(32)) bus ();

  ram_alu_sequencer #(.DW(16), .RW(32), .RD_WAIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM_ALU stand-in: words 0/1 hold X/Y, word 2 reads back the op result
  logic [15:0] mem0;
  logic [15:0] mem1;
  logic [31:0] aluDoutR;
  assign bus.alu_dout = aluDoutR;

  function automatic logic [31:0] aluResult(input logic [1:0] op, input logic [15:0] x,
                                            input logic [15:0] y);
    logic [31:0] xs;
    logic [31:0] ys;
    logic [15:0] d;
    xs = {16'b0, x};
    ys = {16'b0, y};
    d  = x - y;
    case (op)
      2'd0:    return (xs + ys) * (xs - ys);
      2'd1:    return (y == 16'd0) ? 32'd0 : xs % ys;
      2'd2:    return (y == 16'd0) ? 32'd0 : xs / ys;
      default: return (d == 16'd0) ? 32'd0 : xs % {16'b0, d};
    endcase
  endfunction

  // RAM_ALU stand-in storage and registered read port
  always @(posedge clk) begin
    if (bus.alu_e && bus.alu_w && bus.alu_addr == 2'd0) mem0 <= bus.alu_din;
    if (bus.alu_e && bus.alu_w && bus.alu_addr == 2'd1) mem1 <= bus.alu_din;
    if (bus.alu_e && bus.alu_r && bus.alu_addr == 2'd2) aluDoutR <= aluResult(bus.alu_op, mem0, mem1);
  end

  // Activity monitors: accepts, response handshakes, enable cycles, op/data sanity
  int monOn = 0;
  int accCount = 0;
  int rspCount = 0;
  int aluEnCount = 0;
  int badOp = 0;
  int badData = 0;
  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) accCount <= accCount + 1;
    if (bus.rsp_valid && bus.rsp_ready) rspCount <= rspCount + 1;
    if (bus.alu_e) aluEnCount <= aluEnCount + 1;
    if (monOn != 0 && bus.alu_e && bus.alu_op != 2'd3) badOp <= badOp + 1;
    if (monOn != 0 && bus.rsp_valid && bus.rsp_ready && bus.rsp_data != 32'd4) badData <= badData + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  // Present a command at a falling edge and hold it until the accepting rising edge
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) checkOutput("acceptTimeout", {31'b0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic waitResponse(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 40);
    if (!bus.rsp_valid) checkOutput("rspTimeout", {31'b0, bus.rsp_valid}, 32'd1);
  endtask

  // Take the pending response and confirm the return to IDLE one cycle later
  task automatic takeResponse(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idleReady"}, {31'b0, bus.cmd_ready}, 32'd1);
    checkOutput({tag, "_idleBusy"}, {31'b0, bus.busy}, 32'd0);
    checkOutput({tag, "_idleValid"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic runCmd(input string tag, input logic [1:0] op, input logic [15:0] x,
                        input logic [15:0] y, input int expLat, input logic [31:0] expData,
                        input logic expErr);
    int lat;
    applyStimulus(op, x, y);
    waitResponse(lat);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_data"}, bus.rsp_data, expData);
    checkOutput({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, expErr});
    takeResponse(tag);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int snapA;
    int snapB;
    int snapE;
    int highCount;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_x     = 16'd0;
    bus.cmd_y     = 16'd0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmdReady", {31'b0, bus.cmd_ready}, 32'd0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rst_rspValid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_aluE", {31'b0, bus.alu_e}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRst_cmdReady", {31'b0, bus.cmd_ready}, 32'd1);

    // 1: full write/write/read sequence, checked cycle by cycle
    applyStimulus(2'd0, 16'd445, 16'd100);
    @(negedge clk);
    checkOutput("t1_wrx_e", {31'b0, bus.alu_e}, 32'd1);
    checkOutput("t1_wrx_w", {31'b0, bus.alu_w}, 32'd1);
    checkOutput("t1_wrx_addr", {30'b0, bus.alu_addr}, 32'd0);
    checkOutput("t1_wrx_din", {16'b0, bus.alu_din}, 32'd445);
    checkOutput("t1_wrx_cmdReady", {31'b0, bus.cmd_ready}, 32'd0);
    checkOutput("t1_wrx_busy", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    checkOutput("t1_wry_w", {31'b0, bus.alu_w}, 32'd1);
    checkOutput("t1_wry_addr", {30'b0, bus.alu_addr}, 32'd1);
    checkOutput("t1_wry_din", {16'b0, bus.alu_din}, 32'd100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("t1_rd_r", {31'b0, bus.alu_r}, 32'd1);
      checkOutput("t1_rd_w", {31'b0, bus.alu_w}, 32'd0);
      checkOutput("t1_rd_addr", {30'b0, bus.alu_addr}, 32'd2);
      checkOutput("t1_rd_din", {16'b0, bus.alu_din}, 32'd0);
      checkOutput("t1_rd_rspValid", {31'b0, bus.rsp_valid}, 32'd0);
    end
    @(negedge clk);
    checkOutput("t1_resp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    checkOutput("t1_resp_data", bus.rsp_data, 32'd188025);
    checkOutput("t1_resp_err", {31'b0, bus.rsp_err}, 32'd0);
    checkOutput("t1_resp_aluE", {31'b0, bus.alu_e}, 32'd0);
    takeResponse("t1");

    // 2: modulo then divide, back to back
    runCmd("t2_mod", 2'd1, 16'd445, 16'd100, 5, 32'd45, 1'b0);
    runCmd("t2_div", 2'd2, 16'd445, 16'd100, 5, 32'd4, 1'b0);

    // 3: X%(X-Y) normal, then X==Y rejected without RAM_ALU activity
    runCmd("t3_xmod", 2'd3, 16'd1000, 16'd250, 5, 32'd250, 1'b0);
    snapE = aluEnCount;
    runCmd("t3_err", 2'd3, 16'd1000, 16'd1000, 1, 32'd0, 1'b1);
    checkOutput("t3_noAluActivity", aluEnCount - snapE, 32'd0);

    // 4: divide by zero with the consumer stalling for 4 cycles
    applyStimulus(2'd2, 16'd7, 16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t4_valid", {31'b0, bus.rsp_valid}, 32'd1);
      checkOutput("t4_err", {31'b0, bus.rsp_err}, 32'd1);
      checkOutput("t4_data", bus.rsp_data, 32'd0);
      checkOutput("t4_cmdReady", {31'b0, bus.cmd_ready}, 32'd0);
      checkOutput("t4_aluE", {31'b0, bus.alu_e}, 32'd0);
    end
    takeResponse("t4");

    // 5: reset during RD abandons the command, then a fresh command completes
    applyStimulus(2'd1, 16'd9, 16'd4);
    repeat (3) @(negedge clk);
    checkOutput("t5_inRd", {31'b0, bus.alu_r}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_aluE", {31'b0, bus.alu_e}, 32'd0);
    checkOutput("t5_rst_aluR", {31'b0, bus.alu_r}, 32'd0);
    checkOutput("t5_rst_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("t5_rst_cmdReady", {31'b0, bus.cmd_ready}, 32'd0);
    checkOutput("t5_rst_rspValid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("t5_rst_rspData", bus.rsp_data, 32'd0);
    rst = 1'b0;
    highCount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) highCount++;
    end
    checkOutput("t5_noResponse", highCount, 32'd0);
    runCmd("t5_after", 2'd0, 16'd4, 16'd5, 5, 32'hFFFF_FFF7, 1'b0);

    // 6: cmd_valid and rsp_ready held high; one accept per IDLE visit
    snapA = accCount;
    snapB = rspCount;
    snapE = aluEnCount;
    monOn = 1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd3;
    bus.cmd_x     = 16'd9;
    bus.cmd_y     = 16'd4;
    bus.rsp_ready = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    monOn = 0;
    @(negedge clk);
    checkOutput("t6_accepts", accCount - snapA, 32'd3);
    checkOutput("t6_responses", rspCount - snapB, 32'd3);
    checkOutput("t6_aluEnCycles", aluEnCount - snapE, 32'd12);
    checkOutput("t6_aluOpStable", badOp, 32'd0);
    checkOutput("t6_rspData", badData, 32'd0);
    checkOutput("t6_idle", {31'b0, bus.cmd_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
